// File: rtl/wind_sequencer_if.sv
// Control and status bundle of the runway wind sequencer: run controls in, pattern and debug state out.
interface wind_sequencer_if #(
  parameter int N_LIGHTS  = 3,
  parameter int DIV_WIDTH = 25
);
  logic                 enable;
  logic [1:0]           mode;
  logic [1:0]           speed;
  logic [N_LIGHTS-1:0]  lights;
  logic                 tick;
  logic                 heartbeat;
  logic [DIV_WIDTH-1:0] count;
  logic [1:0]           stored_mode;

  // enable/mode/speed are level controls sampled every clk; no valid/ready handshake applies.
  modport master (
    output enable, mode, speed,
    input  lights, tick, heartbeat, count, stored_mode
  );

  modport slave (
    input  enable, mode, speed,
    output lights, tick, heartbeat, count, stored_mode
  );
endinterface

// File: rtl/wind_sequencer.sv
// Runway light sequencer: a prescaler sets the step rate and each tick advances the pattern of the selected mode.
module wind_sequencer #(
    parameter int N_LIGHTS  = 3,
    parameter int DIV_WIDTH = 25
) (
    input logic            clk,
    input logic            reset,
    wind_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_CALM  = 2'b00,
        MODE_R2L   = 2'b01,
        MODE_L2R   = 2'b10,
        MODE_FLASH = 2'b11
    } mode_t;

    function automatic logic [N_LIGHTS-1:0] even_mask();
        logic [N_LIGHTS-1:0] m;
        m = '0;
        for (int i = 0; i < N_LIGHTS; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [N_LIGHTS-1:0] EVEN  = even_mask();
    localparam logic [N_LIGHTS-1:0] ODD   = ~EVEN;
    localparam logic [N_LIGHTS-1:0] ONES  = '1;
    localparam logic [N_LIGHTS-1:0] RIGHT = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [N_LIGHTS-1:0] LEFT  = {1'b1, {(N_LIGHTS-1){1'b0}}};

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] tap_mask;
    logic [N_LIGHTS-1:0]  lights;
    logic [N_LIGHTS-1:0]  start_pattern;
    logic [N_LIGHTS-1:0]  next_lights;
    logic                 heartbeat;
    logic                 tick;
    mode_t                stored_mode;
    mode_t                mode_in;

    assign mode_in = mode_t'(bus.mode);

    // Shifting the all-ones mask right by speed gives a tap width of DIV_WIDTH - speed.
    assign tap_mask = {DIV_WIDTH{1'b1}} >> bus.speed;
    assign tick     = bus.enable && ((count & tap_mask) == tap_mask);

    always_comb begin
        start_pattern = EVEN;
        case (mode_in)
            MODE_CALM:  start_pattern = EVEN;
            MODE_R2L:   start_pattern = RIGHT;
            MODE_L2R:   start_pattern = LEFT;
            MODE_FLASH: start_pattern = ONES;
            default:    start_pattern = EVEN;
        endcase
    end

    // A mode change or an empty pattern restarts; flash-all's dark phase with an unchanged mode
    // lands on the same all-ones value as a restart, so no special case is needed.
    always_comb begin
        next_lights = lights;
        if ((mode_in != stored_mode) || (lights == '0)) begin
            next_lights = start_pattern;
        end else begin
            case (mode_in)
                MODE_CALM:  next_lights = (lights == EVEN) ? ODD : EVEN;
                MODE_R2L:   next_lights = {lights[N_LIGHTS-2:0], lights[N_LIGHTS-1]};
                MODE_L2R:   next_lights = {lights[0], lights[N_LIGHTS-1:1]};
                MODE_FLASH: next_lights = (lights == ONES) ? '0 : ONES;
                default:    next_lights = start_pattern;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            lights      <= '0;
            heartbeat   <= 1'b0;
            stored_mode <= MODE_CALM;
        end else begin
            if (bus.enable) count <= count + 1'b1;
            if (tick) begin
                lights      <= next_lights;
                heartbeat   <= ~heartbeat;
                stored_mode <= mode_in;
            end
        end
    end

    assign bus.lights      = lights;
    assign bus.tick        = tick;
    assign bus.heartbeat   = heartbeat;
    assign bus.count       = count;
    assign bus.stored_mode = stored_mode;

endmodule

// File: tb/tb_wind_sequencer.sv
// Bench for wind_sequencer (N_LIGHTS=3, DIV_WIDTH=4): directed scenarios then random control, against a tick/pattern model.
module tb_wind_sequencer;

  localparam int N_LIGHTS  = 3;
  localparam int DIV_WIDTH = 4;

  logic clk;
  logic reset;

  wind_sequencer_if #(.N_LIGHTS(N_LIGHTS), .DIV_WIDTH(DIV_WIDTH)) bus ();

  wind_sequencer #(.N_LIGHTS(N_LIGHTS), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_count;
  int m_lights;
  int m_hb;
  int m_stored;
  int checks;
  int failures;
  logic [N_LIGHTS-1:0] exp_q[$];

  function automatic int start_of(input int md);
    case (md)
      0: return 5;
      1: return 1;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic int step_of(input int md, input int cur);
    case (md)
      0: return (cur == 5) ? 2 : 5;
      1: return (cur == 4) ? 1 : cur * 2;
      2: return (cur == 1) ? 4 : cur / 2;
      default: return (cur == 7) ? 0 : 7;
    endcase
  endfunction

  function automatic bit model_tick(input bit en, input int spd);
    int period;
    period = 1 << (DIV_WIDTH - spd);
    return en && ((m_count % period) == period - 1);
  endfunction

  task automatic model_reset();
    m_count = 0; m_lights = 0; m_hb = 0; m_stored = 0;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check mid-cycle, then advance model across the next edge.
  task automatic run_cycle(input bit en, input int md, input int spd);
    bit t;
    bus.enable = en;
    bus.mode   = 2'(md);
    bus.speed  = 2'(spd);
    t = model_tick(en, spd);
    @(negedge clk);
    check("tick", int'(bus.tick), int'(t));
    check("lights", int'(bus.lights), m_lights);
    check("heartbeat", int'(bus.heartbeat), m_hb);
    check("count", int'(bus.count), m_count);
    check("stored_mode", int'(bus.stored_mode), m_stored);
    @(posedge clk);
    if (t) begin
      if (md != m_stored || m_lights == 0) m_lights = start_of(md);
      else m_lights = step_of(md, m_lights);
      m_hb ^= 1;
      m_stored = md;
    end
    if (en) m_count = (m_count + 1) % (1 << DIV_WIDTH);
    #1;
    if (t && exp_q.size() > 0) begin
      logic [N_LIGHTS-1:0] e;
      e = exp_q.pop_front();
      check("scoreboard_lights", int'(bus.lights), int'(e));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    bus.enable = 1'b1; bus.mode = 2'b00; bus.speed = 2'd2;
    reset = 1'b0;
    model_reset();
    #3;
    check("reset_lights", int'(bus.lights), 0);
    check("reset_heartbeat", int'(bus.heartbeat), 0);
    check("reset_tick", int'(bus.tick), 0);
    do_reset();

    // Calm from reset: ticks at cycles 3, 7, 11.
    exp_q.push_back(3'b101); exp_q.push_back(3'b010); exp_q.push_back(3'b101);
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 0, 2);
    check("calm_final_lights", int'(bus.lights), 5);
    check("calm_final_hb", int'(bus.heartbeat), 1);
    check("calm_queue_drained", exp_q.size(), 0);

    // Right-to-left from reset.
    do_reset();
    exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    for (int i = 0; i < 16; i++) run_cycle(1'b1, 1, 2);

    // Left-to-right from reset.
    do_reset();
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001); exp_q.push_back(3'b100);
    for (int i = 0; i < 16; i++) run_cycle(1'b1, 2, 2);

    // Mode glitch between ticks is ignored: 001, 010, then 100.
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1, 2);
    check("glitch_pre_lights", int'(bus.lights), 2);
    run_cycle(1'b1, 2, 2);
    run_cycle(1'b1, 1, 2);
    run_cycle(1'b1, 1, 2);
    run_cycle(1'b1, 1, 2);
    check("glitch_post_lights", int'(bus.lights), 4);

    // Real mode change restarts to left-to-right start, then steps.
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1, 2);
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 2, 2);

    // Freeze for 10 cycles mid-interval.
    do_reset();
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 0, 2);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 0, 2);
    check("freeze_count", int'(bus.count), 6);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 0, 2);

    // Flash-all, then asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 9; i++) run_cycle(1'b1, 3, 2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_lights", int'(bus.lights), 0);
    check("async_count", int'(bus.count), 0);
    check("async_hb", int'(bus.heartbeat), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(3'b111); exp_q.push_back(3'b000); exp_q.push_back(3'b111);
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 3, 2);

    // Random control traffic, including speed changes mid-interval.
    exp_q.delete();
    begin
      int md, spd;
      bit en;
      md = 0; spd = 2;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
        if ($urandom_range(0, 31) == 0) spd = $urandom_range(0, 3);
        en = ($urandom_range(0, 9) != 0);
        run_cycle(en, md, spd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
